// File: rtl/rr_mux_arbiter_4.sv
// Four-input round-robin arbiter feeding a single registered output stage.
// Optional ARB_BURST_EN lets a winner keep priority for up to BURST_LEN transfers.
module rr_mux_arbiter_4 #(
    parameter int DATA_W    = 4,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        in_valid,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic [3:0]        in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    input  logic              out_ready
);

    logic [DATA_W-1:0] data_arr [4];
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [1:0]        out_sel_reg;
    logic [1:0]        last_reg;
    logic              load_en;
    logic              grant_en;
    logic              transfer;
    logic [1:0]        rr_winner;
    logic [1:0]        winner;

    assign data_arr[0] = in_data0;
    assign data_arr[1] = in_data1;
    assign data_arr[2] = in_data2;
    assign data_arr[3] = in_data3;

    // The output register can take a new word whenever it is empty or draining.
    assign load_en  = !out_valid_reg || out_ready;
    assign grant_en = !rst && load_en;

    // First valid requester after last_reg, wrapping; k=4 lands back on last_reg.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        rr_winner = last_reg;
        found     = 1'b0;
        idx       = last_reg;
        for (int k = 1; k <= 4; k++) begin
            idx = last_reg + 2'(k);
            if (!found && in_valid[idx]) begin
                rr_winner = idx;
                found     = 1'b1;
            end
        end
    end

`ifdef ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    logic [CNT_W-1:0] burst_cnt_reg;
    logic [CNT_W-1:0] burst_cnt_inc;
    logic             hold;

    // A zero count means the current burst is over (or never started), so rotate.
    assign hold          = in_valid[last_reg] && (burst_cnt_reg != '0);
    assign winner        = hold ? last_reg : rr_winner;
    assign burst_cnt_inc = (winner == last_reg) ? burst_cnt_reg + CNT_W'(1) : CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_reg <= '0;
        end else if (transfer) begin
            burst_cnt_reg <= (burst_cnt_inc == CNT_W'(BURST_LEN)) ? '0 : burst_cnt_inc;
        end else if (load_en && !in_valid[last_reg]) begin
            burst_cnt_reg <= '0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (BURST_LEN > 0);
    assign winner     = rr_winner;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ready
            assign in_ready[gi] = grant_en && in_valid[gi] && (winner == 2'(gi));
        end
    endgenerate

    assign transfer = |in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= 2'd0;
            last_reg      <= 2'd3;
        end else if (transfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_arr[winner];
            out_sel_reg   <= winner;
            last_reg      <= winner;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule
